// File: rtl/multi_tick_gen.sv
// Multi-channel programmable clock-enable generator. Each channel emits a 1-cycle tick or a duty-cycle level.
// Optional build macro MULTI_TICK_GEN_SHADOW_EN holds config writes until the channel's next period boundary.
module multi_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH-1:0]                             en,
  input  logic                                          sync,
  input  logic                                          cfg_wr,
  input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_div,
  input  logic [CNT_W-1:0]                              cfg_high,
  input  logic                                          cfg_mode,
  output logic [NUM_CH-1:0]                             tick_out,
  output logic                                          cfg_err
);

  typedef enum logic {MODE_PULSE = 1'b0, MODE_LEVEL = 1'b1} mode_e;

  localparam int               CH_W     = $clog2((NUM_CH > 1) ? NUM_CH : 2);
  localparam int               CH_X_W   = CH_W + 1;
  localparam logic [CH_X_W-1:0] NUM_CH_X = CH_X_W'(NUM_CH);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic wr_bad;
  logic wr_ok;
  logic cfg_err_q, cfg_err_d;

  // The channel range check is done one bit wider so cfg_ch == NUM_CH is representable.
  assign wr_bad    = (cfg_div == '0) || ({1'b0, cfg_ch} >= NUM_CH_X);
  assign wr_ok     = cfg_wr && !wr_bad;
  assign cfg_err_d = cfg_wr && wr_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    mode_e            mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             sel;
    logic             wrap;

    assign sel  = wr_ok && (cfg_ch == CH_W'(i));
    assign wrap = (count_q == div_q - ONE);

`ifdef MULTI_TICK_GEN_SHADOW_EN
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    mode_e            sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d;
    logic             apply;

    assign apply = wrap || !en[i] || sync;

    always_comb begin
      // NOTE: every next-state signal gets a default before any branch, so no latch can be inferred.
      div_d     = div_q;
      high_d    = high_q;
      mode_d    = mode_q;
      sh_div_d  = sh_div_q;
      sh_high_d = sh_high_q;
      sh_mode_d = sh_mode_q;
      pend_d    = pend_q;
      count_d   = apply ? '0 : count_q + ONE;
      if (apply && pend_q) begin
        div_d  = sh_div_q;
        high_d = sh_high_q;
        mode_d = sh_mode_q;
        pend_d = 1'b0;
      end
      // A write on an apply edge lands in the shadow after the older value has been consumed.
      if (sel) begin
        sh_div_d  = cfg_div;
        sh_high_d = cfg_high;
        sh_mode_d = mode_e'(cfg_mode);
        pend_d    = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_div_q  <= DEF_DIV;
        sh_high_q <= DEF_HIGH;
        sh_mode_q <= MODE_PULSE;
        pend_q    <= 1'b0;
      end else begin
        sh_div_q  <= sh_div_d;
        sh_high_q <= sh_high_d;
        sh_mode_q <= sh_mode_d;
        pend_q    <= pend_d;
      end
    end
`else
    always_comb begin
      div_d   = div_q;
      high_d  = high_q;
      mode_d  = mode_q;
      count_d = (sync || !en[i] || wrap) ? '0 : count_q + ONE;
      if (sel) begin
        div_d   = cfg_div;
        high_d  = cfg_high;
        mode_d  = mode_e'(cfg_mode);
        count_d = '0;
      end
    end
`endif

    assign tick_d = en[i] && ((mode_q == MODE_LEVEL) ? (count_q < high_q) : (count_q == '0));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q <= '0;
        div_q   <= DEF_DIV;
        high_q  <= DEF_HIGH;
        mode_q  <= MODE_PULSE;
        tick_q  <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        count_q <= count_d;
        div_q   <= div_d;
        high_q  <= high_d;
        mode_q  <= mode_d;
        tick_q  <= tick_d;
      end
    end

    assign tick_out[i] = tick_q;
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen: a phase-from-restart reference model predicts every cycle's outputs.
module tb_multi_tick_gen;

  localparam int NCH  = 5;
  localparam int CW   = 16;
  localparam int DEF  = 16;
  localparam int CH_W = 3;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic           err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  en;
  logic            sync;
  logic            cfg_wr;
  logic [CH_W-1:0] cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic [CW-1:0]   cfg_high;
  logic            cfg_mode;
  logic [NCH-1:0]  tick_out;
  logic            cfg_err;

  multi_tick_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_mode(cfg_mode),
    .tick_out(tick_out), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  // Reference: each channel remembers how many cycles have passed since its last phase-0 restart.
  int unsigned m_age [NCH];
  int unsigned m_n   [NCH];
  int unsigned m_h   [NCH];
  bit          m_lvl [NCH];
  bit          m_pend[NCH];
  int unsigned s_n   [NCH];
  int unsigned s_h   [NCH];
  bit          s_lvl [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_age[c] = 0; m_n[c] = DEF; m_h[c] = DEF / 2; m_lvl[c] = 0; m_pend[c] = 0;
      s_n[c] = DEF; s_h[c] = DEF / 2; s_lvl[c] = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    bit bad;
    bit hit;
    int unsigned ph;
    bad   = cfg_wr && (cfg_div == 0 || int'(cfg_ch) >= NCH);
    e.err = bad;
    for (int c = 0; c < NCH; c++) begin
      ph        = m_age[c] % m_n[c];
      e.tick[c] = en[c] && (m_lvl[c] ? (ph < m_h[c]) : (ph == 0));
      hit       = cfg_wr && !bad && (int'(cfg_ch) == c);
`ifdef MULTI_TICK_GEN_SHADOW_EN
      if (m_pend[c] && (sync || !en[c] || ph == m_n[c] - 1)) begin
        m_n[c] = s_n[c]; m_h[c] = s_h[c]; m_lvl[c] = s_lvl[c]; m_pend[c] = 0; m_age[c] = 0;
      end else if (sync || !en[c]) m_age[c] = 0;
      else m_age[c]++;
      if (hit) begin
        s_n[c] = cfg_div; s_h[c] = cfg_high; s_lvl[c] = cfg_mode; m_pend[c] = 1;
      end
`else
      if (sync || !en[c]) m_age[c] = 0;
      else m_age[c]++;
      if (hit) begin
        m_n[c] = cfg_div; m_h[c] = cfg_high; m_lvl[c] = cfg_mode; m_age[c] = 0;
      end
`endif
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising-edge result.
  task automatic cyc(input logic [NCH-1:0] en_v, input logic sync_v, input logic wr_v,
                     input int ch_v, input int div_v, input int high_v, input logic mode_v);
    exp_t e;
    @(negedge clk);
    en = en_v; sync = sync_v; cfg_wr = wr_v; cfg_ch = CH_W'(ch_v);
    cfg_div = CW'(div_v); cfg_high = CW'(high_v); cfg_mode = mode_v;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(en, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int ch_v, input int div_v, input int high_v, input logic mode_v);
    cyc(en, 1'b0, 1'b1, ch_v, div_v, high_v, mode_v);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tick_out", 32'(tick_out), 32'(e.tick));
        check("cfg_err", 32'(cfg_err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b1; en = '0; sync = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_high = '0; cfg_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tick_out", 32'(tick_out), 32'(0));
    check("reset_cfg_err", 32'(cfg_err), 32'(0));
    release_rst();

    // Pulse mode: ch0 divides by 4, the rest stay at the reset ratio.
    wr(0, 4, 0, 1'b0);
    cyc('1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(40);

    // Level mode on ch1: 2-of-5 duty, then always high, then always low.
    wr(1, 5, 2, 1'b1);
    idle(15);
    wr(1, 5, 7, 1'b1);
    idle(10);
    wr(1, 5, 0, 1'b1);
    idle(10);

    // Rejected writes: zero divider, then an out-of-range channel.
    wr(2, 0, 3, 1'b1);
    idle(3);
    wr(NCH, 4, 1, 1'b0);
    idle(20);

    // Two channels pushed out of phase, then realigned by sync.
    wr(0, 3, 0, 1'b0);
    idle(1);
    wr(1, 6, 0, 1'b0);
    idle(4);
    cyc(en, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle(14);

    // Back-to-back writes, and a write coinciding with sync.
    wr(3, 2, 1, 1'b1);
    wr(4, 1, 0, 1'b0);
    cyc(en, 1'b1, 1'b1, 2, 7, 3, 1'b1);
    idle(16);

    // Period change mid-period on ch0.
    wr(0, 8, 0, 1'b0);
    idle(3);
    wr(0, 3, 0, 1'b0);
    idle(20);

    // Reset while ch0 is driving a constant-high level.
    wr(0, 4, 4, 1'b1);
    idle(6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_tick_out", 32'(tick_out), 32'(0));
    check("async_reset_cfg_err", 32'(cfg_err), 32'(0));
    repeat (2) @(posedge clk);
    release_rst();
    idle(40);

    // Randomized traffic, including invalid channels and zero dividers.
    for (int k = 0; k < 2000; k++) begin
      logic [NCH-1:0] en_r;
      en_r = en;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(31, 0) == 0) en_r[c] = ~en_r[c];
      cyc(en_r, ($urandom_range(39, 0) == 0), ($urandom_range(5, 0) == 0),
          int'($urandom_range(7, 0)), int'($urandom_range(9, 0)),
          int'($urandom_range(10, 0)), 1'($urandom_range(1, 0)));
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
